mac_operand_sequencer: RTL

- Upstream control stage for the generic MAC unit.
- On a start pulse it reads ACC_CYCLES operand pairs from two synchronous-read memories and drives operandA, operandB and enable into the MAC. It then waits for the accumulator to settle and captures the accumulated result.
- It presents the captured result downstream with a valid/ready handshake.
- It owns the accumulator clear, so each job starts from zero.

---
 rtl/mac_operand_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mac_operand_sequencer.sv
// Feeds ACC_CYCLES operand pairs from two synchronous-read memories into a MAC,
// then captures the settled accumulator and offers it downstream via valid/ready.
module mac_operand_sequencer #(
  parameter int BITWIDTH_A   = 8,
  parameter int BITWIDTH_B   = 8,
  parameter int ACC_CYCLES   = 400,
  parameter int ADDR_WIDTH   = 9,
  parameter int RES_WIDTH    = 25,
  parameter int PIPE_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseA,
  input  logic [ADDR_WIDTH-1:0] baseB,
  output logic [ADDR_WIDTH-1:0] addrA,
  output logic [ADDR_WIDTH-1:0] addrB,
  input  logic [BITWIDTH_A-1:0] memA_data,
  input  logic [BITWIDTH_B-1:0] memB_data,
  output logic [BITWIDTH_A-1:0] operandA,
  output logic [BITWIDTH_B-1:0] operandB,
  output logic                  enable,
  output logic                  acc_clear,
  input  logic [RES_WIDTH-1:0]  AccResult,
  output logic [RES_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam int LAT_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(ACC_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAST_WAIT  = LAT_W'(PIPE_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, PRIME, ISSUE, DRAIN, HOLD} state_t;

  state_t          state, state_next;
  logic [CNT_W-1:0] issue_cnt;
  logic [LAT_W-1:0] wait_cnt;
  logic            stage1_valid;
  logic            issue_last, pipe_empty, drain_done;
  logic            accept_start, issue_active, issue_step, wait_step, capture_result;

  // issue_cnt is the index of the address currently on addrA/addrB
  assign issue_last = (issue_cnt == LAST_ISSUE);
  assign pipe_empty = !stage1_valid && !enable;
  assign drain_done = pipe_empty && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = PRIME;
      PRIME: state_next = issue_last ? DRAIN : ISSUE;
      ISSUE: if (issue_last) state_next = DRAIN;
      DRAIN: if (drain_done) state_next = HOLD;
      HOLD:  if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_start   = 1'b0;
    issue_active   = 1'b0;
    issue_step     = 1'b0;
    wait_step      = 1'b0;
    capture_result = 1'b0;
    result_valid   = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        accept_start = start;
      end
      PRIME, ISSUE: begin
        issue_active = 1'b1;
        issue_step   = !issue_last;
      end
      DRAIN: begin
        wait_step      = pipe_empty && !drain_done;
        capture_result = drain_done;
      end
      HOLD: result_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // stage1_valid marks read data on memX_data; enable is the second stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrA        <= '0;
      addrB        <= '0;
      operandA     <= '0;
      operandB     <= '0;
      enable       <= 1'b0;
      acc_clear    <= 1'b0;
      result       <= '0;
      stage1_valid <= 1'b0;
      issue_cnt    <= '0;
      wait_cnt     <= '0;
    end else begin
      acc_clear    <= accept_start;
      stage1_valid <= issue_active;
      enable       <= stage1_valid;
      if (stage1_valid) begin
        operandA <= memA_data;
        operandB <= memB_data;
      end
      if (accept_start) begin
        addrA     <= baseA;
        addrB     <= baseB;
        issue_cnt <= '0;
        wait_cnt  <= '0;
      end else if (issue_step) begin
        addrA     <= addrA + ADDR_WIDTH'(1);
        addrB     <= addrB + ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (wait_step)      wait_cnt <= wait_cnt + LAT_W'(1);
      if (capture_result) result   <= AccResult;
    end
  end

endmodule
